rom_stream_ctrl: RTL and testbench
==================================

// Module: rom_stream_ctrl
// PURPOSE
//   Frame sequencer for the sample ROM (addr -> block memory -> 8-bit q).
//   On a start command, reads frame_len_m1+1 consecutive words from a
//   programmable base address and streams them to the FFT input over a
//   valid/ready interface with m_last framing. Hides ROM read latency with
//   a small credit-tracked output FIFO, so backpressure never drops a word.
// PARAMETERS
//   ADDR_W      10   ROM address width; address arithmetic wraps mod 2**ADDR_W
//   DATA_W      8    ROM word / stream data width
//   RD_LAT      1    ROM read latency in cycles (rom_en cycle -> rom_q valid), 1..3
//   FIFO_DEPTH  RD_LAT+2  output FIFO entries (power of two not required)
// PORTS
//   clk          in   1       system clock, all logic on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       frame request; sampled only when busy=0
//   base_addr    in   ADDR_W  first ROM address, latched with start
//   frame_len_m1 in   ADDR_W  beats per frame minus 1, latched with start
//   loop         in   1       continuous mode request (ROM_LOOP_EN only)
//   busy         out  1       frame in progress
//   done         out  1       one-cycle pulse: frame fully delivered
//   rom_en       out  1       ROM read strobe
//   rom_addr     out  ADDR_W  ROM read address
//   rom_q        in   DATA_W  ROM read data, valid RD_LAT cycles after rom_en
//   m_data       out  DATA_W  stream data
//   m_valid      out  1       stream valid
//   m_ready      in   1       stream ready from consumer
//   m_last       out  1       marks final beat of frame (qualified by m_valid)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; busy, done, rom_en, m_valid, m_last = 0;
//   rom_addr, m_data = 0; FIFO, in-flight and beat counters cleared. Reset
//   mid-frame aborts: no done pulse, buffered words discarded.
// - FSM IDLE -> RUN on start&!busy (latch base/len, busy=1 next cycle).
//   RUN -> DRAIN when last read issued; DRAIN -> IDLE on last beat transfer.
//   start while busy=1 is ignored (no queueing).
// - Issue: rom_en=1 in a cycle iff state RUN and inflight+fifo_count <
//   FIFO_DEPTH; rom_addr = base + issue_idx (mod 2**ADDR_W). rom_addr holds
//   when rom_en=0. First rom_en in cycle after start is sampled.
// - Capture: rom_q written to FIFO on the edge ending the cycle RD_LAT after
//   each rom_en; credits guarantee the FIFO never overflows.
// - Stream: m_valid = FIFO non-empty (registered head). Transfer on
//   m_valid&m_ready. m_data/m_last stable while m_valid&!m_ready.
//   m_last=1 on beat index frame_len_m1 only.
// - Latency: start in cycle 0 -> first m_valid in cycle RD_LAT+2. With m_ready
//   held 1, one beat per cycle, no bubbles.
// - done pulses cycle after last beat transfers; busy=0 that same cycle, so a
//   start in the done cycle is accepted (back-to-back frames).
// - frame_len_m1=0 -> single beat with m_last=1; all-ones -> 2**ADDR_W beats.
// - Beat/issue counters are ADDR_W+1 bits to distinguish full-span frames.
// CONFIGURATION
//   ROM_LOOP_EN defined: if loop=1 when the last read of a frame is issued,
//   FSM stays RUN and reissues from base_addr with no gap; m_last still marks
//   every frame end; done is not pulsed for looped frames; after loop drops,
//   the current frame completes normally with done.
//   ROM_LOOP_EN undefined: loop port present but ignored; single-shot only.
// TESTING (bench ROM model: rom[a] = a[7:0], RD_LAT=1)
//   1 base=0,len_m1=7,m_ready=1 -> m_data 0..7 in cycles 3..10, m_last cycle 10,
//     done cycle 11, busy 1 in cycles 1..10.
//   2 same frame, m_ready toggling 1,0,1,0 -> 0..7 in order, no loss/dup, data
//     stable when stalled, rom_en never with inflight+count=FIFO_DEPTH.
//   3 base=1020,len_m1=7 -> rom_addr 1020..1023,0..3; m_data 252..255,0..3.
//   4 start pulsed mid-frame -> ignored; len_m1=0 -> one beat with m_last, done.
//   5 rst_n low after 4th beat -> outputs 0 immediately; new start base=5,len=3
//     yields 5,6,7,8 with done.
//   6 ROM_LOOP_EN, base=0,len_m1=3,loop=1 -> 0,1,2,3,0,1,2,3 contiguous, m_last
//     on each 3, no done; drop loop -> frame ends, single done.

Source files
------------

// File: rtl/rom_stream_if.sv
// rom_stream_if: ROM read port plus valid/ready sample stream for rom_stream_ctrl.
//   master : controller side  (drives rom_en/rom_addr and the m_* stream)
//   slave  : ROM + consumer   (drives rom_q and m_ready)
interface rom_stream_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      output rom_en, rom_addr, m_data, m_valid, m_last,
      input  rom_q, m_ready
   );

   modport slave (
      input  rom_en, rom_addr, m_data, m_valid, m_last,
      output rom_q, m_ready
   );
endinterface

// File: rtl/rom_stream_ctrl.sv
// rom_stream_ctrl: frame sequencer for the sample ROM.
// On start, reads frame_len_m1+1 consecutive words beginning at base_addr
// (wrapping mod 2**ADDR_W) and streams them out with m_last on the final beat.
// ROM latency is hidden by a small output FIFO; reads are only issued while
// in-flight reads plus buffered words leave room, so backpressure never drops
// a word.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               frame request, accepted only when idle
//   base_addr           first ROM address (latched on start)
//   frame_len_m1        beats per frame minus one (latched on start)
//   loop                continuous mode request (only with ROM_LOOP_EN)
//   busy                frame in progress
//   done                one-cycle pulse after the last beat transfers
//   bus (master)        rom_en/rom_addr/rom_q and m_data/m_valid/m_ready/m_last
// Build option: define ROM_LOOP_EN to enable continuous (looped) frames;
// without it the loop input is ignored.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | issuing ROM reads for the frame
// DRAIN | all reads issued, emptying pipeline and FIFO
module rom_stream_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = RD_LAT + 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] frame_len_m1,
   input  logic              loop,
   output logic              busy,
   output logic              done,
   rom_stream_if.master      bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] base_q, len_q, addr_last_q, addr_issue;
   logic [ADDR_W:0]   issue_idx, beat_idx;
   logic [RD_LAT-1:0] rd_pipe;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count, inflight, used;
   logic              done_q, loop_en, issue, last_issue, capture;
   logic              head_valid, xfer, last_xfer, start_ok;

`ifdef ROM_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = loop & 1'b0;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reads issued but not yet captured into the FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
   end

   assign used       = inflight + fifo_count;
   assign issue      = (state == RUN) && (used < CNT_W'(FIFO_DEPTH));
   assign last_issue = issue && (issue_idx == {1'b0, len_q});
   assign addr_issue = base_q + issue_idx[ADDR_W-1:0];
   assign capture    = rd_pipe[RD_LAT-1];
   assign head_valid = (fifo_count != '0);
   assign xfer       = head_valid && bus.m_ready;
   assign start_ok   = start && (state == IDLE);
   // In DRAIN nothing more is issued, so the word leaving an otherwise empty
   // pipeline is the frame's final beat (looped frames may still be buffered
   // ahead of it, so m_last alone is not enough).
   assign last_xfer  = (state == DRAIN) && xfer && (inflight == '0) && (fifo_count == CNT_W'(1));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_issue && !loop_en) state_nxt = DRAIN;
         DRAIN:   if (last_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.rom_en   = issue;
   assign bus.rom_addr = issue ? addr_issue : addr_last_q;
   assign bus.m_data   = fifo_mem[rd_ptr];
   assign bus.m_valid  = head_valid;
   assign bus.m_last   = head_valid && (beat_idx == {1'b0, len_q});
   assign busy         = (state != IDLE);
   assign done         = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         addr_last_q <= '0;
         issue_idx   <= '0;
         beat_idx    <= '0;
         rd_pipe     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= last_xfer;
         if (start_ok) begin
            base_q    <= base_addr;
            len_q     <= frame_len_m1;
            issue_idx <= '0;
            beat_idx  <= '0;
         end
         if (issue) begin
            addr_last_q <= addr_issue;
            issue_idx   <= last_issue ? '0 : issue_idx + 1'b1;
         end
         rd_pipe[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         if (capture) begin
            fifo_mem[wr_ptr] <= bus.rom_q;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (xfer) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            beat_idx <= (beat_idx == {1'b0, len_q}) ? '0 : beat_idx + 1'b1;
         end
         unique case ({capture, xfer})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Bench for rom_stream_ctrl with a 1-cycle ROM returning rom[a] = a[7:0].
module tb_rom_stream_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 3;

   logic              clk = 1'b0;
   logic              rst_n, start, loop, busy, done;
   logic [ADDR_W-1:0] base_addr, frame_len_m1;

   rom_stream_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   rom_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_addr    (base_addr),
      .frame_len_m1 (frame_len_m1),
      .loop         (loop),
      .busy         (busy),
      .done         (done),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.rom_q <= '0;
      else if (bus.rom_en) bus.rom_q <= bus.rom_addr[7:0];
   end

   int n_pass = 0, n_total = 0, proto_err = 0;
   int first_valid, done_cyc, busy_cyc, last_xfer, busy_at_done;
   logic [7:0] got_data[$];
   logic       got_last[$];
   logic [9:0] got_addr[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic chk_zero(input string p);
      chk({p, " busy"}, int'(busy), 0);
      chk({p, " done"}, int'(done), 0);
      chk({p, " rom_en"}, int'(bus.rom_en), 0);
      chk({p, " rom_addr"}, int'(bus.rom_addr), 0);
      chk({p, " m_valid"}, int'(bus.m_valid), 0);
      chk({p, " m_last"}, int'(bus.m_last), 0);
      chk({p, " m_data"}, int'(bus.m_data), 0);
   endtask

   // rmode: 0 ready held 1, 1 toggling, 2 random. Cycle 0 is the start cycle.
   task automatic run_frame(input logic [9:0] b, input logic [9:0] l, input int rmode,
                            input bit pre_started, input int poke_at, input int loop_until);
      int  issued, xfr;
      bit  pv, pr, pl, fin;
      logic [7:0] pd;
      got_data.delete(); got_last.delete(); got_addr.delete();
      first_valid = -1; done_cyc = -1; busy_cyc = 0; last_xfer = -1; busy_at_done = -1;
      if (!pre_started) @(negedge clk);
      start = 1'b1; base_addr = b; frame_len_m1 = l; loop = (loop_until > 0);
      issued = 0; xfr = 0; pv = 0; pr = 0; pl = 0; pd = '0; fin = 0;
      for (int k = 1; k <= 6000 && !fin; k++) begin
         @(negedge clk);
         if (k == poke_at) begin
            start = 1'b1; base_addr = b ^ 10'h155; frame_len_m1 = l ^ 10'h3;
         end else start = 1'b0;
         if (loop_until > 0 && k >= loop_until) loop = 1'b0;
         case (rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = (k % 2 == 1);
            default: bus.m_ready = ($urandom_range(0, 2) != 0);
         endcase
         #1;
         if (busy) busy_cyc++;
         if (bus.rom_en) begin issued++; got_addr.push_back(bus.rom_addr); end
         if (issued - xfr > DEPTH) proto_err++;
         if (bus.m_last && !bus.m_valid) proto_err++;
         if (pv && !pr && (!bus.m_valid || bus.m_data != pd || bus.m_last != pl)) proto_err++;
         if (bus.m_valid && first_valid < 0) first_valid = k;
         if (bus.m_valid && bus.m_ready) begin
            got_data.push_back(bus.m_data); got_last.push_back(bus.m_last);
            xfr++; last_xfer = k;
         end
         if (done) begin done_cyc = k; busy_at_done = busy; fin = 1; end
         pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data; pl = bus.m_last;
      end
      chk("frame completes", int'(fin), 1);
   endtask

   task automatic check_frame(input string nm, input int b, input int l, input int nfr);
      int n, de, le, ae, idx;
      n = nfr * (l + 1);
      chk({nm, " beat count"}, got_data.size(), n);
      chk({nm, " read count"}, got_addr.size(), n);
      de = 0; le = 0; ae = 0;
      for (int i = 0; i < got_data.size() && i < n; i++) begin
         idx = (b + i % (l + 1)) % 1024;
         if (int'(got_data[i]) != idx % 256) de++;
         if (int'(got_last[i]) != int'(i % (l + 1) == l)) le++;
      end
      for (int i = 0; i < got_addr.size() && i < n; i++) begin
         idx = (b + i % (l + 1)) % 1024;
         if (int'(got_addr[i]) != idx) ae++;
      end
      chk({nm, " data errors"}, de, 0);
      chk({nm, " m_last errors"}, le, 0);
      chk({nm, " rom_addr errors"}, ae, 0);
      chk({nm, " done after last beat"}, done_cyc, last_xfer + 1);
      chk({nm, " busy low with done"}, busy_at_done, 0);
   endtask

   typedef struct {
      logic [9:0] base;
      logic [9:0] len;
      int         rmode;
      int         exp_first;
      int         exp_done;   // -1: not fixed (stalling consumer)
      int         exp_busy;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b, l, poke, nb;
      bit pre;
      vecs[0] = '{10'd0,    10'd7,    0, 3, 11,   10};
      vecs[1] = '{10'd0,    10'd7,    1, 3, -1,   -1};
      vecs[2] = '{10'd1020, 10'd7,    0, 3, 11,   10};
      vecs[3] = '{10'd0,    10'd0,    0, 3, 4,    3};
      vecs[4] = '{10'd5,    10'd3,    2, 3, -1,   -1};
      vecs[5] = '{10'd1023, 10'd1023, 0, 3, 1027, 1026};

      rst_n = 1'b0; start = 1'b0; loop = 1'b0; base_addr = '0; frame_len_m1 = '0;
      bus.m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_frame(vecs[i].base, vecs[i].len, vecs[i].rmode, 0, 0, -1);
         check_frame($sformatf("vec%0d", i), int'(vecs[i].base), int'(vecs[i].len), 1);
         chk($sformatf("vec%0d first m_valid", i), first_valid, vecs[i].exp_first);
         if (vecs[i].exp_done >= 0) begin
            chk($sformatf("vec%0d done cycle", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("vec%0d busy cycles", i), busy_cyc, vecs[i].exp_busy);
         end
      end

      // start while busy is ignored
      run_frame(10'd0, 10'd7, 0, 0, 5, -1);
      check_frame("poke", 0, 7, 1);
      chk("poke done cycle", done_cyc, 11);

      // back-to-back: start in the done cycle
      run_frame(10'd10, 10'd2, 0, 0, 0, -1);
      run_frame(10'd20, 10'd4, 0, 1, 0, -1);
      check_frame("b2b", 20, 4, 1);
      chk("b2b first m_valid", first_valid, 3);
      chk("b2b done cycle", done_cyc, 8);

      // reset after 4th beat aborts the frame
      @(negedge clk);
      start = 1'b1; base_addr = 10'd0; frame_len_m1 = 10'd20; bus.m_ready = 1'b1;
      nb = 0;
      for (int k = 1; k <= 50 && nb < 4; k++) begin
         @(negedge clk); start = 1'b0; #1;
         if (bus.m_valid && bus.m_ready) nb++;
      end
      chk("abort beats before reset", nb, 4);
      @(negedge clk) rst_n = 1'b0;
      #1 chk_zero("mid-frame reset");
      @(negedge clk) rst_n = 1'b1;
      run_frame(10'd5, 10'd3, 0, 0, 0, -1);
      check_frame("after reset", 5, 3, 1);
      chk("after reset done cycle", done_cyc, 7);

`ifdef ROM_LOOP_EN
      // loop drops at cycle 9: frame-end reads in cycles 4 and 8 see loop=1,
      // the one in cycle 12 sees 0, so three frames stream back to back.
      run_frame(10'd0, 10'd3, 0, 0, 0, 9);
      check_frame("loop", 0, 3, 3);
      chk("loop done cycle", done_cyc, 15);
`else
      run_frame(10'd0, 10'd3, 0, 0, 0, 9);
      check_frame("loop ignored", 0, 3, 1);
      chk("loop ignored done cycle", done_cyc, 7);
`endif

      for (int r = 0; r < 10; r++) begin
         b    = $urandom_range(0, 1023);
         l    = $urandom_range(0, 30);
         poke = (l >= 10) ? $urandom_range(2, 6) : 0;
         pre  = (r > 0) && ($urandom_range(0, 1) == 1);
         run_frame(10'(b), 10'(l), 2, pre, poke, -1);
         check_frame($sformatf("rand%0d", r), b, l, 1);
         chk($sformatf("rand%0d first m_valid", r), first_valid, 3);
      end

      chk("protocol violations", proto_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
